// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one step
// per cycle, with HI/LO result registers and direct MTHI/MTLO writes.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opnd1,
    input  logic [WIDTH-1:0] opnd2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a, b, acc, rq;
    logic             div_mode, neg_q, neg_r, div0;

    logic             load, step, fix_wr, mt_hi, mt_lo;
    logic             s1, s2;
    logic [WIDTH-1:0] a_in, b_in;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] acc_nxt, rq_nxt;
    logic [2*WIDTH-1:0] prod, prod_fin;
    logic [WIDTH-1:0] quot, rem, hi_fix, lo_fix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush wins over every busy-state transition
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !flush && !op[2]) state_nxt = S_CALC;
            S_CALC: if (flush)             state_nxt = S_IDLE;
                    else if (cnt == LAST)  state_nxt = S_FIX;
            S_FIX:  state_nxt = flush ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy   = (state != S_IDLE);
        done   = (state == S_DONE) && !flush;
        load   = (state == S_IDLE) && start && !flush && !op[2];
        mt_hi  = (state == S_IDLE) && start && !flush && (op == 3'b100);
        mt_lo  = (state == S_IDLE) && start && !flush && (op == 3'b101);
        step   = (state == S_CALC) && !flush;
        fix_wr = (state == S_FIX)  && !flush;
    end

    // Operand magnitudes; even opcodes (MULT/DIV) are the signed ones
    always_comb begin
        s1   = !op[0] && opnd1[WIDTH-1];
        s2   = !op[0] && opnd2[WIDTH-1];
        a_in = s1 ? -opnd1 : opnd1;
        b_in = s2 ? -opnd2 : opnd2;
    end

    // One iteration: acc/rq hold {product high, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, (rq[0] ? a : '0)};
        div_shift = {acc, rq[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, b});
        if (div_mode) begin
            acc_nxt = div_ok ? (div_shift[WIDTH-1:0] - b) : div_shift[WIDTH-1:0];
            rq_nxt  = {rq[WIDTH-2:0], div_ok};
        end else begin
            acc_nxt = mul_sum[WIDTH:1];
            rq_nxt  = {mul_sum[0], rq[WIDTH-1:1]};
        end
    end

    // Sign correction; a divide by zero returns all-ones and the original dividend
    always_comb begin
        prod     = {acc, rq};
        prod_fin = neg_q ? -prod : prod;
        quot     = div0 ? '1 : (neg_q ? -rq : rq);
        rem      = div0 ? (neg_r ? -a : a) : (neg_r ? -acc : acc);
        hi_fix   = div_mode ? rem  : prod_fin[2*WIDTH-1:WIDTH];
        lo_fix   = div_mode ? quot : prod_fin[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a        <= '0;
            b        <= '0;
            acc      <= '0;
            rq       <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt      <= '0;
            a        <= a_in;
            b        <= b_in;
            acc      <= '0;
            rq       <= op[1] ? a_in : b_in;
            div_mode <= op[1];
            neg_q    <= s1 ^ s2;
            neg_r    <= s1;
            div0     <= (opnd2 == '0);
        end else if (step) begin
            cnt <= cnt + CW'(1);
            acc <= acc_nxt;
            rq  <= rq_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_wr) begin
            hi <= hi_fix;
            lo <= lo_fix;
        end else begin
            if (mt_hi) hi <= opnd1;
            if (mt_lo) lo <= opnd1;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed mul/div/MT vectors, flush, busy-start and
// mid-operation reset, with result and done-cycle checking in a separate monitor.
module tb_mdu_iter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] opnd1 = '0;
    logic [WIDTH-1:0] opnd2 = '0;
    logic             flush = 1'b0;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .opnd1(opnd1), .opnd2(opnd2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one start; when push is set, expect done WIDTH+1 edges after the sampling edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic push, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; opnd1 = x; opnd2 = y;
        @(posedge clk);
        #1;
        if (push) begin
            e.hi = eh; e.lo = el; e.cyc = cyc + WIDTH + 1;
            sb.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check("idle_timeout", busy, 32'd0);
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el);
        issue(o, x, y, 1'b1, eh, el);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;

        run(3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run(3'b011, 32'd100,       32'd7,        32'd2,         32'd14);
        run(3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);
        run(3'b011, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF);
        run(3'b010, 32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF);
        run(3'b000, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'h0,        32'h0000_0018);
        run(3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);

        // MTHI / MTLO write at the sampling edge without going busy
        issue(3'b100, 32'h1234, 32'h0, 1'b0, 32'h0, 32'h0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", busy, 32'd0);
        check("mthi_done", done, 32'd0);
        issue(3'b101, 32'h5678, 32'h0, 1'b0, 32'h0, 32'h0);
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi", hi, 32'h1234);
        check("mtlo_busy", busy, 32'd0);

        // Reserved opcode is ignored
        issue(3'b110, 32'hDEAD, 32'hBEEF, 1'b0, 32'h0, 32'h0);
        check("op110_busy", busy, 32'd0);
        check("op110_hi", hi, 32'h1234);
        check("op110_lo", lo, 32'h5678);

        // flush and start together in IDLE: start is dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b100; opnd1 = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_hi", hi, 32'h1234);
        check("flush_start_busy", busy, 32'd0);

        // A second start mid-divide is ignored; only the DIV result appears
        issue(3'b010, 32'd100, 32'hFFFF_FFF6, 1'b1, 32'h0, 32'hFFFF_FFF6);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 3'b000; opnd1 = 32'd2; opnd2 = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("busy_start_busy", busy, 32'd0);

        // flush mid-multiply: back to IDLE, registers untouched, no done
        issue(3'b000, 32'd3, 32'd3, 1'b0, 32'h0, 32'h0);
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 32'd0);
        check("flush_hi", hi, 32'h0);
        check("flush_lo", lo, 32'hFFFF_FFF6);
        repeat (40) @(negedge clk);
        check("flush_hi_late", hi, 32'h0);
        check("flush_lo_late", lo, 32'hFFFF_FFF6);

        // Reset mid-divide aborts at once
        run(3'b001, 32'd6, 32'd7, 32'h0, 32'd42);
        issue(3'b011, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 32'd0);
        check("midrst_done", done, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(3'b011, 32'd1000, 32'd3, 32'd1, 32'd333);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
